// File: rtl/rv32i_lsu_if.sv
// rv32i_lsu_if: valid/ready data-bus bundle between the load/store unit and
// the data memory. A single request channel carries address, write enable,
// byte strobes and write data. A separate read-return channel carries the
// read word.
//
//   O_MEM_VALID  LSU -> mem  request valid
//   O_MEM_WE     LSU -> mem  1 = write
//   O_MEM_ADDR   LSU -> mem  word-aligned byte address
//   O_MEM_WSTRB  LSU -> mem  byte-lane enables (0 for reads)
//   O_MEM_WDATA  LSU -> mem  lane-replicated write data
//   I_MEM_READY  mem -> LSU  request accepted this cycle
//   I_MEM_RVALID mem -> LSU  read data valid
//   I_MEM_RDATA  mem -> LSU  read word
interface rv32i_lsu_if;
  logic        O_MEM_VALID;
  logic        O_MEM_WE;
  logic [31:0] O_MEM_ADDR;
  logic [3:0]  O_MEM_WSTRB;
  logic [31:0] O_MEM_WDATA;
  logic        I_MEM_READY;
  logic        I_MEM_RVALID;
  logic [31:0] I_MEM_RDATA;

  modport master (
    output O_MEM_VALID, O_MEM_WE, O_MEM_ADDR, O_MEM_WSTRB, O_MEM_WDATA,
    input  I_MEM_READY, I_MEM_RVALID, I_MEM_RDATA
  );

  modport slave (
    input  O_MEM_VALID, O_MEM_WE, O_MEM_ADDR, O_MEM_WSTRB, O_MEM_WDATA,
    output I_MEM_READY, I_MEM_RVALID, I_MEM_RDATA
  );
endinterface

// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RV32I load/store unit with a single outstanding bus transaction.
// It takes the EX-stage effective address and rs2 data. It checks request
// legality (type, funct3, alignment) and issues one bus request. Store data
// is replicated across byte lanes and strobed. Load data is extracted and
// sign- or zero-extended, then returned to writeback. All outputs are
// registered.
//
// Ports:
//   I_CLK, I_RSTN      clock (rising edge), asynchronous active-low reset
//   I_REQ ... I_RD_IDX request from EX; sampled only while O_BUSY=0
//   O_BUSY             transaction in progress; the core stalls
//   O_ERR_REQ          1-cycle pulse for an illegal or misaligned request
//   O_ERR_TIMEOUT      1-cycle pulse when a transaction is aborted
//   mem                data-bus master (see rv32i_lsu_if)
//   O_WB_VALID         1-cycle pulse with O_WB_RD_IDX / O_WB_DATA
//   O_WB_DATA          held until the next writeback
module rv32i_lsu #(
  parameter int P_TIMEOUT_CYC = 255
) (
  input  logic               I_CLK,
  input  logic               I_RSTN,
  input  logic               I_REQ,
  input  logic               I_IS_LD,
  input  logic               I_IS_ST,
  input  logic [2:0]         I_FUNCT3,
  input  logic [31:0]        I_ADDR,
  input  logic [31:0]        I_ST_DATA,
  input  logic [4:0]         I_RD_IDX,
  output logic               O_BUSY,
  output logic               O_ERR_REQ,
  output logic               O_ERR_TIMEOUT,
  rv32i_lsu_if.master        mem,
  output logic               O_WB_VALID,
  output logic [4:0]         O_WB_RD_IDX,
  output logic [31:0]        O_WB_DATA
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  // The counter value of the last permitted cycle. The transaction may
  // spend at most P_TIMEOUT_CYC cycles in REQ+WAIT_RD.
  localparam logic [7:0] LP_CNT_LAST = 8'(P_TIMEOUT_CYC - 1);
  localparam logic       LP_TO_EN    = (P_TIMEOUT_CYC != 0);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  a_q;
  logic [2:0]  f3_q;
  logic        is_ld_q;

  logic        busy_q;
  logic        err_req_q;
  logic        err_to_q;
  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        illegal_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] rd_shift_d;
  logic [7:0]  ld_byte_d;
  logic [15:0] ld_half_d;
  logic [31:0] ld_data_d;
  logic        timeout_hit_d;

  // Request legality. The checks are ordered so that each type is tested
  // against its own funct3 space before the alignment checks.
  always_comb begin
    illegal_d = 1'b0;
    if (I_IS_LD == I_IS_ST) begin
      illegal_d = 1'b1;
    end else if (I_IS_LD && (I_FUNCT3 == 3'd3 || I_FUNCT3 == 3'd6 || I_FUNCT3 == 3'd7)) begin
      illegal_d = 1'b1;
    end else if (I_IS_ST && (I_FUNCT3 >= 3'd3)) begin
      illegal_d = 1'b1;
    end else if ((I_FUNCT3[1:0] == 2'b01) && I_ADDR[0]) begin
      illegal_d = 1'b1;
    end else if ((I_FUNCT3[1:0] == 2'b10) && (I_ADDR[1:0] != 2'b00)) begin
      illegal_d = 1'b1;
    end
  end

  // Store lanes. Data is replicated so that the memory only needs the
  // strobes to pick the right bytes.
  always_comb begin
    wstrb_d = 4'b1111;
    wdata_d = I_ST_DATA;
    case (I_FUNCT3[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << I_ADDR[1:0];
        wdata_d = {4{I_ST_DATA[7:0]}};
      end
      2'b01: begin
        wstrb_d = I_ADDR[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{I_ST_DATA[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = I_ST_DATA;
      end
    endcase
  end

  // Load extraction uses the latched low address bits and funct3.
  always_comb begin
    rd_shift_d = mem.I_MEM_RDATA >> {a_q, 3'b000};
    ld_byte_d  = rd_shift_d[7:0];
    ld_half_d  = a_q[1] ? mem.I_MEM_RDATA[31:16] : mem.I_MEM_RDATA[15:0];
    case (f3_q)
      3'd0:    ld_data_d = {{24{ld_byte_d[7]}}, ld_byte_d};
      3'd1:    ld_data_d = {{16{ld_half_d[15]}}, ld_half_d};
      3'd4:    ld_data_d = {24'd0, ld_byte_d};
      3'd5:    ld_data_d = {16'd0, ld_half_d};
      default: ld_data_d = mem.I_MEM_RDATA;
    endcase
  end

  assign timeout_hit_d = LP_TO_EN && (cnt_q == LP_CNT_LAST);

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      a_q         <= 2'd0;
      f3_q        <= 3'd0;
      is_ld_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_req_q   <= 1'b0;
      err_to_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wstrb_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
    end else begin
      err_req_q  <= 1'b0;
      err_to_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (I_REQ) begin
            if (illegal_d) begin
              err_req_q <= 1'b1;
            end else begin
              a_q         <= I_ADDR[1:0];
              f3_q        <= I_FUNCT3;
              is_ld_q     <= I_IS_LD;
              wb_rd_q     <= I_RD_IDX;
              mem_valid_q <= 1'b1;
              mem_we_q    <= I_IS_ST;
              mem_addr_q  <= {I_ADDR[31:2], 2'b00};
              mem_wstrb_q <= I_IS_ST ? wstrb_d : 4'd0;
              mem_wdata_q <= I_IS_ST ? wdata_d : 32'd0;
              busy_q      <= 1'b1;
              cnt_q       <= 8'd0;
              state_q     <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // A store handshake completes the transaction and takes priority
          // over a timeout on the same cycle. A load handshake does not.
          if (mem.I_MEM_READY && !is_ld_q) begin
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else if (timeout_hit_d) begin
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_to_q    <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (mem.I_MEM_READY) begin
              mem_valid_q <= 1'b0;
              state_q     <= S_WAIT_RD;
            end
          end
        end

        S_WAIT_RD: begin
          if (mem.I_MEM_RVALID) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= ld_data_d;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else if (timeout_hit_d) begin
            busy_q   <= 1'b0;
            err_to_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin
          busy_q      <= 1'b0;
          mem_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign O_BUSY          = busy_q;
  assign O_ERR_REQ       = err_req_q;
  assign O_ERR_TIMEOUT   = err_to_q;
  assign mem.O_MEM_VALID = mem_valid_q;
  assign mem.O_MEM_WE    = mem_we_q;
  assign mem.O_MEM_ADDR  = mem_addr_q;
  assign mem.O_MEM_WSTRB = mem_wstrb_q;
  assign mem.O_MEM_WDATA = mem_wdata_q;
  assign O_WB_VALID      = wb_valid_q;
  assign O_WB_RD_IDX     = wb_rd_q;
  assign O_WB_DATA       = wb_data_q;

endmodule
